// File: rtl/capture_buffer.sv
// Pre/post-trigger capture RAM on the ADC clock: keeps PRE_TRIG samples of history,
// fills the rest of the frame after the trigger, then freezes it for the display reader.
module capture_buffer #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 9,
  parameter int PRE_TRIG = 128
) (
  input  logic              clk_AD,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_DI,
  input  logic              trigger_in,
  input  logic              arm,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_ready,
  input  logic              frame_ack,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  // Terminal counts: the write that completes the pre-fill and the frame, respectively.
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] start_ptr;
  logic [ADDR_W-1:0] pre_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W-1:0] rd_idx_p0;
  logic [DATA_W-1:0] rd_data_p1;
  logic              wr_en;
  logic              trig_take;

  function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] a,
                                                 input logic [ADDR_W-1:0] b);
    return a + b;
  endfunction

  function automatic logic [ADDR_W-1:0] wrap_sub(input logic [ADDR_W-1:0] a,
                                                 input logic [ADDR_W-1:0] b);
    return a - b;
  endfunction

  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    trig_take  = 1'b0;
    unique case (state)
      IDLE: begin
        if (arm) state_next = PRE;
      end
      PRE: begin
        wr_en = 1'b1;
        if (pre_cnt == PRE_LAST) state_next = ARMED;
      end
      ARMED: begin
        wr_en = 1'b1;
        if (trigger_in) begin
          trig_take  = 1'b1;
          state_next = POST;
        end
      end
      POST: begin
        wr_en = 1'b1;
        if (post_cnt == POST_LAST) state_next = DONE;
      end
      DONE: begin
        if (frame_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control: state, pointers, counters; status flags registered from the next state
  // so they line up with the state register.
  always_ff @(posedge clk_AD) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      start_ptr   <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      frame_ready <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      frame_ready <= (state_next == DONE);
      busy        <= (state_next inside {PRE, ARMED, POST});
      if (wr_en) wr_ptr <= wrap_add(wr_ptr, ADDR_W'(1));
      if (state == IDLE && arm) begin
        pre_cnt <= '0;
      end else if (state == PRE) begin
        pre_cnt <= pre_cnt + 1'b1;
      end
      if (trig_take) begin
        start_ptr <= wrap_sub(wr_ptr, PRE_OFS);
        post_cnt  <= ADDR_W'(1);
      end else if (state == POST) begin
        post_cnt <= post_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_AD) begin
    if (wr_en) mem[wr_ptr] <= sample_DI;
  end

  // Read stage p0 -> p1: logical index rotated onto the physical frame start.
  assign rd_idx_p0 = wrap_add(start_ptr, rd_addr);

  always_ff @(posedge clk_AD) begin
    if (!rst_n) begin
      rd_data_p1 <= '0;
    end else begin
      rd_data_p1 <= mem[rd_idx_p0];
    end
  end

  assign rd_data = rd_data_p1;

endmodule
